// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - framebuffer write-port owner: CLEAR/DRAW/HOLD frame sequencing
// with round-robin arbitration, clipping and address generation for two pixel writers.
module fb_write_scheduler #(
  parameter int         PX_WIDTH  = 128,
  parameter int         PX_HEIGHT = 96,
  parameter int         IDLE_MAX  = 1000,
  parameter logic [2:0] CLR_COLOR = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [8:0]  r0_x,
  input  logic [8:0]  r0_y,
  input  logic [2:0]  r0_color,
  input  logic        r0_done,
  output logic        r0_ack,
  input  logic        r1_req,
  input  logic [8:0]  r1_x,
  input  logic [8:0]  r1_y,
  input  logic [2:0]  r1_color,
  input  logic        r1_done,
  output logic        r1_ack,
  output logic        frame_start,
  output logic        clearing,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [2:0]  mem_din,
  output logic [7:0]  frame_cnt
);

  localparam int NPIX = PX_WIDTH * PX_HEIGHT;
  localparam int HW   = (IDLE_MAX > 1) ? $clog2(IDLE_MAX) : 1;

  typedef enum logic [1:0] {S_CLEAR, S_DRAW, S_HOLD} state_t;

  state_t        state;
  logic [16:0]   clr_cnt;
  logic [HW-1:0] hold_cnt;
  logic          rr_ptr;
  logic          done0;
  logic          done1;

  logic          grant0;
  logic          grant1;
  logic [8:0]    sel_x;
  logic [8:0]    sel_y;
  logic [2:0]    sel_color;
  logic          sel_on;

  // rr_ptr names the requester that wins when both ask in the same cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_DRAW) begin
      if (r0_req && (!r1_req || !rr_ptr))
        grant0 = 1'b1;
      else if (r1_req)
        grant1 = 1'b1;
    end
  end

  assign r0_ack   = grant0;
  assign r1_ack   = grant1;
  assign clearing = (state == S_CLEAR);

  assign sel_x     = grant1 ? r1_x : r0_x;
  assign sel_y     = grant1 ? r1_y : r0_y;
  assign sel_color = grant1 ? r1_color : r0_color;

  // Sign bit rejects negatives, so the low 8 bits can be treated as unsigned.
  assign sel_on = !sel_x[8] && !sel_y[8] &&
                  (int'(sel_x[7:0]) < PX_WIDTH) && (int'(sel_y[7:0]) < PX_HEIGHT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_CLEAR;
      clr_cnt     <= '0;
      hold_cnt    <= '0;
      rr_ptr      <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
    end else begin
      mem_we      <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        S_CLEAR: begin
          if (clr_cnt == 17'(NPIX)) begin
            state       <= S_DRAW;
            frame_start <= 1'b1;
            clr_cnt     <= '0;
            done0       <= 1'b0;
            done1       <= 1'b0;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= clr_cnt[15:0];
            mem_din  <= CLR_COLOR;
            clr_cnt  <= clr_cnt + 17'd1;
          end
        end
        S_DRAW: begin
          if (grant0 || grant1) begin
            mem_we   <= sel_on;
            mem_addr <= 16'(int'(sel_y[7:0]) * PX_WIDTH + int'(sel_x[7:0]));
            mem_din  <= sel_color;
            rr_ptr   <= grant0;
          end
          done0 <= done0 | r0_done;
          done1 <= done1 | r1_done;
          if (done0 && done1) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HW'(IDLE_MAX - 1)) begin
            state     <= S_CLEAR;
            hold_cnt  <= '0;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb/tb_fb_write_scheduler.sv - self-checking bench for fb_write_scheduler
module tb_fb_write_scheduler;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int IM = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic [8:0]  r0_x = '0, r0_y = '0, r1_x = '0, r1_y = '0;
  logic [2:0]  r0_color = '0, r1_color = '0;
  logic        r0_done = 1'b0, r1_done = 1'b0;
  logic        r0_ack, r1_ack, frame_start, clearing, mem_we;
  logic [15:0] mem_addr;
  logic [2:0]  mem_din;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  int ptr      = 0;
  bit exp_we   = 1'b0;
  int exp_addr = 0;
  int exp_din  = 0;

  fb_write_scheduler #(
    .PX_WIDTH (W),
    .PX_HEIGHT(H),
    .IDLE_MAX (IM),
    .CLR_COLOR(3'b000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .r0_req     (r0_req),
    .r0_x       (r0_x),
    .r0_y       (r0_y),
    .r0_color   (r0_color),
    .r0_done    (r0_done),
    .r0_ack     (r0_ack),
    .r1_req     (r1_req),
    .r1_x       (r1_x),
    .r1_y       (r1_y),
    .r1_color   (r1_color),
    .r1_done    (r1_done),
    .r1_ack     (r1_ack),
    .frame_start(frame_start),
    .clearing   (clearing),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit on_screen(input int x, input int y);
    return (x >= 0) && (x < W) && (y >= 0) && (y < H);
  endfunction

  task automatic check_write();
    check("mem_we", int'(mem_we), int'(exp_we));
    if (exp_we) begin
      check("mem_addr", int'(mem_addr), exp_addr);
      check("mem_din", int'(mem_din), exp_din);
    end
    exp_we = 1'b0;
  endtask

  // One DRAW cycle: drive both requesters, check last cycle's write and this cycle's grant.
  task automatic draw_cycle(input bit q0, input int x0, input int y0, input int c0,
                            input bit q1, input int x1, input int y1, input int c1,
                            input bit d0, input bit d1, output int who);
    int x, y, c;
    r0_req = q0; r0_x = 9'(x0); r0_y = 9'(y0); r0_color = 3'(c0); r0_done = d0;
    r1_req = q1; r1_x = 9'(x1); r1_y = 9'(y1); r1_color = 3'(c1); r1_done = d1;
    #1;
    check_write();
    check("frame_start_low", int'(frame_start), 0);
    if (q0 && q1)  who = ptr;
    else if (q0)   who = 0;
    else if (q1)   who = 1;
    else           who = -1;
    check("r0_ack", int'(r0_ack), int'(who == 0));
    check("r1_ack", int'(r1_ack), int'(who == 1));
    if (who >= 0) begin
      x = (who == 0) ? x0 : x1;
      y = (who == 0) ? y0 : y1;
      c = (who == 0) ? c0 : c1;
      ptr      = 1 - who;
      exp_we   = on_screen(x, y);
      exp_addr = y * W + x;
      exp_din  = c;
    end
    @(negedge clk);
    r0_done = 1'b0;
    r1_done = 1'b0;
  endtask

  // Called at the negedge of the first CLEAR cycle; returns in the cycle after frame_start.
  task automatic run_clear();
    r0_req = 1'b1;
    r1_req = 1'b1;
    for (int i = 0; i < W * H; i++) begin
      @(negedge clk);
      #1;
      check("clr_we", int'(mem_we), 1);
      check("clr_addr", int'(mem_addr), i);
      check("clr_din", int'(mem_din), 0);
      check("clr_flag", int'(clearing), 1);
      check("clr_noack", int'(r0_ack | r1_ack), 0);
    end
    @(negedge clk);
    r0_req = 1'b0;
    r1_req = 1'b0;
    #1;
    check("frame_start", int'(frame_start), 1);
    check("draw_not_clearing", int'(clearing), 0);
    check("draw_first_we", int'(mem_we), 0);
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  initial begin
    int who, n, idx0, idx1;
    bit seen;
    bit pq[2];
    int px[2], py[2], pc[2];

    // Reset state
    r0_req = 1'b1;
    r1_req = 1'b1;
    @(negedge clk);
    #1;
    check("rst_we", int'(mem_we), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_din", int'(mem_din), 0);
    check("rst_fs", int'(frame_start), 0);
    check("rst_fcnt", int'(frame_cnt), 0);
    check("rst_clearing", int'(clearing), 1);
    check("rst_noack", int'(r0_ack | r1_ack), 0);
    @(negedge clk);
    rst = 1'b1;
    run_clear();

    // Both requesting continuously: grants alternate starting with r0
    idx0 = 0;
    idx1 = 0;
    for (int k = 0; k < 6; k++) begin
      draw_cycle(1'b1, idx0, 0, idx0 + 1, 1'b1, idx1, 1, idx1 + 4, 1'b0, 1'b0, who);
      check("rr_seq", who, k % 2);
      if (who == 0) idx0++;
      else if (who == 1) idx1++;
    end

    // Lone r0 pixel (3,2) colour 5 -> address 19
    draw_cycle(1'b1, 3, 2, 5, 1'b0, 0, 0, 0, 1'b0, 1'b0, who);
    check("r0_lone_grant", who, 0);
    r0_req = 1'b0;
    #1;
    check("addr_3_2", int'(mem_addr), 19);
    check("din_3_2", int'(mem_din), 5);
    check("we_3_2", int'(mem_we), 1);
    #1;

    // Clipped r1 pixels
    draw_cycle(1'b0, 0, 0, 0, 1'b1, -1, 0, 7, 1'b0, 1'b0, who);
    draw_cycle(1'b0, 0, 0, 0, 1'b1,  W, 0, 7, 1'b0, 1'b0, who);
    draw_cycle(1'b0, 0, 0, 0, 1'b1,  0, H, 7, 1'b0, 1'b0, who);
    draw_cycle(1'b0, 0, 0, 0, 1'b0,  0, 0, 0, 1'b0, 1'b0, who);

    // Randomized traffic; each requester holds its pixel until acked
    pq[0] = 1'b0;
    pq[1] = 1'b0;
    for (int k = 0; k < 80; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pq[r] && ($urandom_range(0, 2) != 0)) begin
          pq[r] = 1'b1;
          px[r] = int'($urandom_range(0, W + 5)) - 3;
          py[r] = int'($urandom_range(0, H + 5)) - 3;
          pc[r] = int'($urandom_range(0, 7));
        end
      end
      draw_cycle(pq[0], px[0], py[0], pc[0], pq[1], px[1], py[1], pc[1], 1'b0, 1'b0, who);
      if (who >= 0) pq[who] = 1'b0;
    end

    // r0_done, then r1_done 5 cycles later; DRAW keeps granting in between
    draw_cycle(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 1'b0, who);
    for (int k = 0; k < 4; k++) begin
      draw_cycle(1'b1, k, 3, 2, 1'b0, 0, 0, 0, 1'b0, 1'b0, who);
      check("ack_after_one_done", who, 0);
    end
    draw_cycle(1'b0, 0, 0, 0, 1'b1, 2, 1, 6, 1'b0, 1'b1, who);

    // Last DRAW cycle carries the pixel acked with r1_done
    r0_req = 1'b0;
    r1_req = 1'b0;
    #1;
    check_write();
    check("last_draw_clearing", int'(clearing), 0);
    n = 1;
    seen = 1'b0;
    @(negedge clk);
    r0_req = 1'b1;
    r1_req = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      #1;
      if (clearing) begin
        seen = 1'b1;
      end else begin
        n++;
        check("hold_we", int'(mem_we), 0);
        check("hold_noack", int'(r0_ack | r1_ack), 0);
        @(negedge clk);
      end
    end
    check("clear_restart_seen", int'(seen), 1);
    check("draw_plus_hold_len", n, 1 + IM);
    check("frame_cnt_1", int'(frame_cnt), 1);
    check("clear_entry_we", int'(mem_we), 0);

    // Second CLEAR up to address 17, then asynchronous reset mid-cycle
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      r0_done = (i == 3);
      r1_done = (i == 3);
      #1;
      check("clr2_we", int'(mem_we), 1);
      check("clr2_addr", int'(mem_addr), i);
      check("clr2_noack", int'(r0_ack | r1_ack), 0);
    end
    r0_done = 1'b0;
    r1_done = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_clr_we", int'(mem_we), 0);
    check("arst_clr_addr", int'(mem_addr), 0);
    check("arst_clr_fcnt", int'(frame_cnt), 0);
    check("arst_clr_clearing", int'(clearing), 1);
    @(negedge clk);
    rst = 1'b1;
    ptr = 0;
    run_clear();

    // Reset midway through DRAW
    draw_cycle(1'b1, 1, 1, 3, 1'b0, 0, 0, 0, 1'b0, 1'b0, who);
    r0_req = 1'b0;
    #1;
    check_write();
    rst = 1'b0;
    #1;
    check("arst_draw_we", int'(mem_we), 0);
    check("arst_draw_addr", int'(mem_addr), 0);
    check("arst_draw_din", int'(mem_din), 0);
    check("arst_draw_fs", int'(frame_start), 0);
    check("arst_draw_clearing", int'(clearing), 1);
    check("arst_draw_fcnt", int'(frame_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    ptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("clr3_addr", int'(mem_addr), i);
      check("clr3_we", int'(mem_we), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Owns the single framebuffer write port (mem_we/mem_addr/mem_din into memory) and sequences the per-frame cycle: CLEAR, then DRAW, then HOLD.
- In DRAW, two pixel writers share the port under a round-robin arbiter with a req/ack handshake: requester 0 is the scene renderer, requester 1 is the HUD/score overlay.
- Clipping and address generation are centralised here, so requesters only present signed x/y and a colour.

Parameters:
- PX_WIDTH, 128, framebuffer width in pixels.
- PX_HEIGHT, 96, framebuffer height in pixels. PX_WIDTH*PX_HEIGHT must be ≤ 65536.
- IDLE_MAX, 1000, number of HOLD cycles between end of DRAW and the next CLEAR.
- CLR_COLOR, 3'b000, colour written during CLEAR.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- r0_req  in  1  requester 0 has a pixel pending.
- r0_x  in  9  requester 0 pixel x, signed.
- r0_y  in  9  requester 0 pixel y, signed.
- r0_color  in  3  requester 0 pixel colour.
- r0_done  in  1  single-cycle pulse: requester 0 has finished its frame.
- r0_ack  out  1  pixel accepted this cycle (combinational).
- r1_req, r1_x, r1_y, r1_color, r1_done, r1_ack  same as requester 0, for requester 1.
- frame_start  out  1  single-cycle pulse on entry to DRAW.
- clearing  out  1  high while in CLEAR.
- mem_we  out  1  framebuffer write enable (registered).
- mem_addr  out  16  framebuffer write address = y*PX_WIDTH + x (registered).
- mem_din  out  3  framebuffer write data (registered).
- frame_cnt  out  8  number of completed frames, wraps at 255→0.

Behaviour:
- Reset, asserted (rst=0), asynchronous:
  - state=CLEAR, clear counter=0, rr pointer=0, done flags=0, frame_cnt=0, hold counter=0.
  - mem_we=0, mem_addr=0, mem_din=0, frame_start=0.
  - Reset mid-operation aborts any CLEAR, DRAW or HOLD; after release the cycle restarts with CLEAR from address 0.
- CLEAR:
  - One write per cycle: mem_we=1, mem_din=CLR_COLOR, mem_addr=counter, for counter 0 to PX_WIDTH*PX_HEIGHT-1 in order.
  - First write appears on the cycle after reset release; a full clear is exactly PX_WIDTH*PX_HEIGHT write cycles.
  - Once the final address is registered, next state is DRAW.
  - clearing=1 throughout CLEAR.
  - No acks are issued in CLEAR.
- DRAW entry:
  - frame_start=1 for exactly the first DRAW cycle.
  - Both done flags are cleared on entry.
- DRAW arbitration:
  - At most one ack per cycle.
  - Only one requester asserting req: it is acked.
  - Both asserting req: the requester selected by rr pointer is acked, and the pointer then moves to the other requester.
  - A lone grant also sets the pointer to the other requester.
  - With continuous requests from both, grants alternate 0,1,0,1.
- DRAW handshake:
  - Requester holds req/x/y/color stable until it sees ack.
  - Requester may present a new pixel the cycle after ack.
  - Latency: the write appears on mem_* exactly 1 cycle after ack.
  - Cycles with no ack drive mem_we=0.
- Clipping:
  - A pixel with x<0, x≥PX_WIDTH, y<0 or y≥PX_HEIGHT is still acked, but mem_we=0 for its write slot.
  - Address arithmetic uses the full signed range, with no wrap into valid rows.
- Done tracking:
  - rN_done in DRAW sets sticky flag N.
  - Simultaneous done pulses set both flags.
  - done in the same cycle as an ack for the same requester: the acked pixel is still written.
  - When both flags are set (flags registered), next state is HOLD. Pending requests are not acked after that cycle.
  - done pulses outside DRAW are ignored.
- HOLD:
  - mem_we=0, no acks.
  - Counter runs 0 to IDLE_MAX-1; on reaching IDLE_MAX-1, go to CLEAR, reset the counter and increment frame_cnt (mod 256).
- Port ownership: no write reaches mem_* except via CLEAR or an acked pixel; mem_we is never asserted in HOLD.

Test Plan:
- Reset release with PX_WIDTH=8, PX_HEIGHT=4 → 32 consecutive writes, addr 0..31, din=0, then frame_start pulse exactly 1 cycle later; no ack during those 32 cycles.
- DRAW, r0 only, pixel (3,2) colour 5 → r0_ack same cycle; next cycle mem_we=1, addr=19, din=5.
- Both requesting continuously for 6 cycles → acks r0,r1,r0,r1,r0,r1 with the pointer starting at 0; mem writes follow each ack by 1 cycle with the correct requester's data.
- Clipping: r1 pixels (-1,0), (8,0), (0,4) → each acked, and mem_we=0 in each following cycle.
- r0_done then r1_done 5 cycles later, with IDLE_MAX=10 → HOLD entered after the second flag; exactly 10 HOLD cycles with mem_we=0; CLEAR restarts at addr 0; frame_cnt 0→1.
- Assert rst low midway through CLEAR (addr 17) and midway through DRAW → outputs are 0 immediately (asynchronously); after release, CLEAR restarts at addr 0 and frame_cnt=0.
